// File: rtl/commit_trace_rob_if.sv
// Commit-trace bus: issue allocation, execution-unit writeback and the
// in-order trace beat toward the difftest checker.
interface commit_trace_rob_if #(
    parameter int unsigned ARCH_LEN  = 32,
    parameter int unsigned NUM_WARPS = 8,
    parameter int unsigned NUM_LANES = 16,
    parameter int unsigned REG_BITS  = 8,
    parameter int unsigned DEPTH     = 8
);
    localparam int unsigned WARP_ID_BITS = $clog2(NUM_WARPS);
    localparam int unsigned TAG_BITS     = $clog2(DEPTH);
    localparam int unsigned DATA_W       = NUM_LANES * ARCH_LEN;

    logic                    alloc_valid;
    logic                    alloc_ready;
    logic [ARCH_LEN-1:0]     alloc_pc;
    logic [WARP_ID_BITS-1:0] alloc_warpId;
    logic [1:0]              alloc_numRegs;
    logic [TAG_BITS-1:0]     alloc_tag;

    logic                    wb_valid;
    logic [TAG_BITS-1:0]     wb_tag;
    logic [1:0]              wb_slot;
    logic [REG_BITS-1:0]     wb_address;
    logic [DATA_W-1:0]       wb_data;

    logic                    trace_valid;
    logic [ARCH_LEN-1:0]     trace_pc;
    logic [WARP_ID_BITS-1:0] trace_warpId;
    logic                    trace_regs_0_enable;
    logic [REG_BITS-1:0]     trace_regs_0_address;
    logic [DATA_W-1:0]       trace_regs_0_data;
    logic                    trace_regs_1_enable;
    logic [REG_BITS-1:0]     trace_regs_1_address;
    logic [DATA_W-1:0]       trace_regs_1_data;
    logic                    trace_regs_2_enable;
    logic [REG_BITS-1:0]     trace_regs_2_address;
    logic [DATA_W-1:0]       trace_regs_2_data;

    logic                    err;

    // Issue/writeback/checker side.
    modport master (
        output alloc_valid, alloc_pc, alloc_warpId, alloc_numRegs,
        output wb_valid, wb_tag, wb_slot, wb_address, wb_data,
        input  alloc_ready, alloc_tag,
        input  trace_valid, trace_pc, trace_warpId,
        input  trace_regs_0_enable, trace_regs_0_address, trace_regs_0_data,
        input  trace_regs_1_enable, trace_regs_1_address, trace_regs_1_data,
        input  trace_regs_2_enable, trace_regs_2_address, trace_regs_2_data,
        input  err
    );

    // Reorder-buffer side.
    modport slave (
        input  alloc_valid, alloc_pc, alloc_warpId, alloc_numRegs,
        input  wb_valid, wb_tag, wb_slot, wb_address, wb_data,
        output alloc_ready, alloc_tag,
        output trace_valid, trace_pc, trace_warpId,
        output trace_regs_0_enable, trace_regs_0_address, trace_regs_0_data,
        output trace_regs_1_enable, trace_regs_1_address, trace_regs_1_data,
        output trace_regs_2_enable, trace_regs_2_address, trace_regs_2_data,
        output err
    );
endinterface

// File: rtl/commit_trace_rob.sv
// Reorder buffer that gathers out-of-order register writebacks per
// instruction and emits one in-order commit trace beat per instruction.
module commit_trace_rob #(
    parameter int unsigned ARCH_LEN  = 32,
    parameter int unsigned NUM_WARPS = 8,
    parameter int unsigned NUM_LANES = 16,
    parameter int unsigned REG_BITS  = 8,
    parameter int unsigned DEPTH     = 8
) (
    input logic               clock,
    input logic               reset,
    commit_trace_rob_if.slave bus_io
);
    localparam int unsigned WARP_ID_BITS = $clog2(NUM_WARPS);
    localparam int unsigned TAG_BITS     = $clog2(DEPTH);
    localparam int unsigned DATA_W       = NUM_LANES * ARCH_LEN;
    localparam int unsigned CNT_BITS     = TAG_BITS + 1;

    // Entry storage
    logic [DEPTH-1:0]        valid_q;
    logic [ARCH_LEN-1:0]     pc_q     [DEPTH];
    logic [WARP_ID_BITS-1:0] warp_q   [DEPTH];
    logic [1:0]              expect_q [DEPTH];
    logic [2:0]              filled_q [DEPTH];
    logic [REG_BITS-1:0]     addr_q   [DEPTH][3];
    logic [DATA_W-1:0]       data_q   [DEPTH][3];

    // Control state
    logic [TAG_BITS-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;

    // Trace output registers
    logic                    trace_valid_q, trace_valid_d;
    logic [ARCH_LEN-1:0]     trace_pc_q, trace_pc_d;
    logic [WARP_ID_BITS-1:0] trace_warp_q, trace_warp_d;
    logic [2:0]              trace_en_q, trace_en_d;
    logic [REG_BITS-1:0]     trace_addr_q [3];
    logic [REG_BITS-1:0]     trace_addr_d [3];
    logic [DATA_W-1:0]       trace_data_q [3];
    logic [DATA_W-1:0]       trace_data_d [3];

    logic       alloc_fire, wb_ok, wb_fire, retire;
    logic [3:0] wb_filled;
    logic [1:0] head_pop;

    // Decode allocation, writeback legality and retirement from registered state.
    always_comb begin
        alloc_fire = bus_io.alloc_valid && ready_q;
        // Slot 3 reads as already filled so it can never be accepted.
        wb_filled  = {1'b1, filled_q[bus_io.wb_tag]};
        wb_ok      = valid_q[bus_io.wb_tag] && !wb_filled[bus_io.wb_slot] &&
                     (bus_io.wb_slot < expect_q[bus_io.wb_tag]);
        wb_fire    = bus_io.wb_valid && wb_ok;
        head_pop   = {1'b0, filled_q[head_q][0]} + {1'b0, filled_q[head_q][1]} +
                     {1'b0, filled_q[head_q][2]};
        retire     = valid_q[head_q] && (head_pop == expect_q[head_q]);
    end

    // Next-state for pointers, occupancy, ready, sticky error and trace beat.
    always_comb begin
        head_d        = retire ? head_q + TAG_BITS'(1) : head_q;
        tail_d        = alloc_fire ? tail_q + TAG_BITS'(1) : tail_q;
        count_d       = count_q + CNT_BITS'(alloc_fire) - CNT_BITS'(retire);
        ready_d       = count_d < CNT_BITS'(DEPTH);
        err_d         = err_q | (bus_io.wb_valid && !wb_ok);
        trace_valid_d = 1'b0;
        trace_pc_d    = '0;
        trace_warp_d  = '0;
        trace_en_d    = '0;
        for (int k = 0; k < 3; k++) begin
            trace_addr_d[k] = '0;
            trace_data_d[k] = '0;
        end
        if (retire) begin
            trace_valid_d = 1'b1;
            trace_pc_d    = pc_q[head_q];
            trace_warp_d  = warp_q[head_q];
            trace_en_d    = filled_q[head_q];
            for (int k = 0; k < 3; k++) begin
                if (filled_q[head_q][k]) begin
                    trace_addr_d[k] = addr_q[head_q][k];
                    trace_data_d[k] = data_q[head_q][k];
                end
            end
        end
    end

    // Control and trace output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            ready_q       <= 1'b0;
            err_q         <= 1'b0;
            trace_valid_q <= 1'b0;
            trace_pc_q    <= '0;
            trace_warp_q  <= '0;
            trace_en_q    <= '0;
            for (int k = 0; k < 3; k++) begin
                trace_addr_q[k] <= '0;
                trace_data_q[k] <= '0;
            end
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            ready_q       <= ready_d;
            err_q         <= err_d;
            trace_valid_q <= trace_valid_d;
            trace_pc_q    <= trace_pc_d;
            trace_warp_q  <= trace_warp_d;
            trace_en_q    <= trace_en_d;
            for (int k = 0; k < 3; k++) begin
                trace_addr_q[k] <= trace_addr_d[k];
                trace_data_q[k] <= trace_data_d[k];
            end
        end
    end

    // Entry storage: allocate at tail, fill on writeback, invalidate on retire.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                filled_q[i] <= '0;
            end
        end else begin
            if (alloc_fire) begin
                valid_q[tail_q]  <= 1'b1;
                pc_q[tail_q]     <= bus_io.alloc_pc;
                warp_q[tail_q]   <= bus_io.alloc_warpId;
                expect_q[tail_q] <= bus_io.alloc_numRegs;
                filled_q[tail_q] <= '0;
            end
            if (retire) begin
                valid_q[head_q] <= 1'b0;
            end
            // Never the tail entry: writebacks only land on already-valid entries.
            if (wb_fire) begin
                filled_q[bus_io.wb_tag][bus_io.wb_slot] <= 1'b1;
                addr_q[bus_io.wb_tag][bus_io.wb_slot]   <= bus_io.wb_address;
                data_q[bus_io.wb_tag][bus_io.wb_slot]   <= bus_io.wb_data;
            end
        end
    end

    assign bus_io.alloc_ready          = ready_q;
    assign bus_io.alloc_tag            = tail_q;
    assign bus_io.trace_valid          = trace_valid_q;
    assign bus_io.trace_pc             = trace_pc_q;
    assign bus_io.trace_warpId         = trace_warp_q;
    assign bus_io.trace_regs_0_enable  = trace_en_q[0];
    assign bus_io.trace_regs_0_address = trace_addr_q[0];
    assign bus_io.trace_regs_0_data    = trace_data_q[0];
    assign bus_io.trace_regs_1_enable  = trace_en_q[1];
    assign bus_io.trace_regs_1_address = trace_addr_q[1];
    assign bus_io.trace_regs_1_data    = trace_data_q[1];
    assign bus_io.trace_regs_2_enable  = trace_en_q[2];
    assign bus_io.trace_regs_2_address = trace_addr_q[2];
    assign bus_io.trace_regs_2_data    = trace_data_q[2];
    assign bus_io.err                  = err_q;
endmodule

// File: tb/tb_commit_trace_rob.sv
// Directed self-checking bench for commit_trace_rob.
module tb_commit_trace_rob;
    localparam int unsigned ARCH_LEN  = 32;
    localparam int unsigned NUM_WARPS = 8;
    localparam int unsigned NUM_LANES = 16;
    localparam int unsigned REG_BITS  = 8;
    localparam int unsigned DEPTH     = 8;
    localparam int unsigned DATA_W    = NUM_LANES * ARCH_LEN;

    logic clock = 1'b0;
    logic reset;

    commit_trace_rob_if #(
        .ARCH_LEN (ARCH_LEN),
        .NUM_WARPS(NUM_WARPS),
        .NUM_LANES(NUM_LANES),
        .REG_BITS (REG_BITS),
        .DEPTH    (DEPTH)
    ) bus ();

    commit_trace_rob #(
        .ARCH_LEN (ARCH_LEN),
        .NUM_WARPS(NUM_WARPS),
        .NUM_LANES(NUM_LANES),
        .REG_BITS (REG_BITS),
        .DEPTH    (DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus_io(bus.slave)
    );

    always #5 clock = ~clock;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] beat_pc_q[$];

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                            input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] lanes(input logic [31:0] base);
        logic [DATA_W-1:0] v;
        v = '0;
        for (int g = 0; g < NUM_LANES; g++) v[ARCH_LEN*g +: ARCH_LEN] = base + 32'(g);
        return v;
    endfunction

    // Advance one cycle and sample 1 time unit after the edge; log every beat seen.
    task automatic tick();
        @(posedge clock);
        #1;
        if (bus.trace_valid) beat_pc_q.push_back(bus.trace_pc);
    endtask

    task automatic idle();
        bus.alloc_valid   = 1'b0;
        bus.alloc_pc      = '0;
        bus.alloc_warpId  = '0;
        bus.alloc_numRegs = '0;
        bus.wb_valid      = 1'b0;
        bus.wb_tag        = '0;
        bus.wb_slot       = '0;
        bus.wb_address    = '0;
        bus.wb_data       = '0;
    endtask

    task automatic set_alloc(input logic [31:0] pc, input logic [2:0] warp,
                             input logic [1:0] n);
        bus.alloc_valid   = 1'b1;
        bus.alloc_pc      = pc;
        bus.alloc_warpId  = warp;
        bus.alloc_numRegs = n;
    endtask

    task automatic set_wb(input logic [2:0] tag, input logic [1:0] slot,
                          input logic [7:0] addr, input logic [DATA_W-1:0] data);
        bus.wb_valid   = 1'b1;
        bus.wb_tag     = tag;
        bus.wb_slot    = slot;
        bus.wb_address = addr;
        bus.wb_data    = data;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic expect_beat(input string t, input logic [31:0] pc, input logic [2:0] warp,
                               input logic [2:0] en, input logic [7:0] a0, input logic [7:0] a1,
                               input logic [7:0] a2, input logic [DATA_W-1:0] d0,
                               input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2);
        check_eq({t, "_valid"}, DATA_W'(bus.trace_valid), DATA_W'(1));
        check_eq({t, "_pc"}, DATA_W'(bus.trace_pc), DATA_W'(pc));
        check_eq({t, "_warp"}, DATA_W'(bus.trace_warpId), DATA_W'(warp));
        check_eq({t, "_en"}, DATA_W'({bus.trace_regs_2_enable, bus.trace_regs_1_enable,
                                       bus.trace_regs_0_enable}), DATA_W'(en));
        check_eq({t, "_a0"}, DATA_W'(bus.trace_regs_0_address), DATA_W'(a0));
        check_eq({t, "_a1"}, DATA_W'(bus.trace_regs_1_address), DATA_W'(a1));
        check_eq({t, "_a2"}, DATA_W'(bus.trace_regs_2_address), DATA_W'(a2));
        check_eq({t, "_d0"}, bus.trace_regs_0_data, d0);
        check_eq({t, "_d1"}, bus.trace_regs_1_data, d1);
        check_eq({t, "_d2"}, bus.trace_regs_2_data, d2);
    endtask

    // kind 0: unallocated tag, 1: slot >= expected, 2: slot 3, 3: same-cycle alloc.
    task automatic err_case(input int kind);
        string t;
        t = $sformatf("err%0d", kind);
        do_reset();
        set_alloc(32'h40, 3'd0, 2'd1);
        tick();
        idle();
        check_eq({t, "_clear"}, DATA_W'(bus.err), DATA_W'(0));
        case (kind)
            0: set_wb(3'd4, 2'd0, 8'h1, lanes(32'h1));
            1: set_wb(3'd0, 2'd1, 8'h1, lanes(32'h1));
            2: set_wb(3'd0, 2'd3, 8'h1, lanes(32'h1));
            default: begin
                set_alloc(32'h44, 3'd0, 2'd1);
                set_wb(3'd1, 2'd0, 8'h1, lanes(32'h1));
            end
        endcase
        tick();
        idle();
        check_eq({t, "_set"}, DATA_W'(bus.err), DATA_W'(1));
        tick();
        tick();
        check_eq({t, "_nobeat"}, DATA_W'(bus.trace_valid), DATA_W'(0));
        check_eq({t, "_sticky"}, DATA_W'(bus.err), DATA_W'(1));
    endtask

    initial begin
        logic [2:0] exp_tag;
        idle();

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        check_eq("rst_valid", DATA_W'(bus.trace_valid), DATA_W'(0));
        check_eq("rst_err", DATA_W'(bus.err), DATA_W'(0));
        check_eq("rst_ready", DATA_W'(bus.alloc_ready), DATA_W'(0));
        check_eq("rst_tag", DATA_W'(bus.alloc_tag), DATA_W'(0));
        check_eq("rst_pc", DATA_W'(bus.trace_pc), DATA_W'(0));
        reset = 1'b0;
        tick();
        check_eq("rst_ready_after", DATA_W'(bus.alloc_ready), DATA_W'(1));

        // Single instruction
        set_alloc(32'h8000_0000, 3'd3, 2'd1);
        tick();
        idle();
        check_eq("t1_tag_adv", DATA_W'(bus.alloc_tag), DATA_W'(1));
        set_wb(3'd0, 2'd0, 8'd5, lanes(32'h0));
        tick();
        idle();
        check_eq("t1_nobeat_t1", DATA_W'(bus.trace_valid), DATA_W'(0));
        tick();
        expect_beat("t1", 32'h8000_0000, 3'd3, 3'b001, 8'd5, 8'd0, 8'd0, lanes(32'h0), '0, '0);
        tick();
        check_eq("t1_gone", DATA_W'(bus.trace_valid), DATA_W'(0));
        check_eq("t1_pc_zero", DATA_W'(bus.trace_pc), DATA_W'(0));
        check_eq("t1_d0_zero", bus.trace_regs_0_data, '0);

        // Reordering: B completes before A
        do_reset();
        set_alloc(32'hA0, 3'd1, 2'd1);
        tick();
        set_alloc(32'hB0, 3'd2, 2'd1);
        check_eq("t2_tagB", DATA_W'(bus.alloc_tag), DATA_W'(1));
        tick();
        idle();
        set_wb(3'd1, 2'd0, 8'd7, lanes(32'h100));
        tick();
        idle();
        check_eq("t2_nobeat_a", DATA_W'(bus.trace_valid), DATA_W'(0));
        tick();
        check_eq("t2_nobeat_b", DATA_W'(bus.trace_valid), DATA_W'(0));
        tick();
        check_eq("t2_nobeat_c", DATA_W'(bus.trace_valid), DATA_W'(0));
        set_wb(3'd0, 2'd0, 8'd6, lanes(32'h200));
        tick();
        idle();
        check_eq("t2_nobeat_d", DATA_W'(bus.trace_valid), DATA_W'(0));
        tick();
        expect_beat("t2A", 32'hA0, 3'd1, 3'b001, 8'd6, 8'd0, 8'd0, lanes(32'h200), '0, '0);
        tick();
        expect_beat("t2B", 32'hB0, 3'd2, 3'b001, 8'd7, 8'd0, 8'd0, lanes(32'h100), '0, '0);
        tick();
        check_eq("t2_end", DATA_W'(bus.trace_valid), DATA_W'(0));

        // Zero-reg then 3-reg filled out of order
        do_reset();
        set_alloc(32'h100, 3'd4, 2'd0);
        tick();
        set_alloc(32'h200, 3'd5, 2'd3);
        check_eq("t3_nobeat", DATA_W'(bus.trace_valid), DATA_W'(0));
        tick();
        idle();
        expect_beat("t3Z", 32'h100, 3'd4, 3'b000, 8'd0, 8'd0, 8'd0, '0, '0, '0);
        set_wb(3'd1, 2'd2, 8'h22, lanes(32'h2200));
        tick();
        check_eq("t3_wait_a", DATA_W'(bus.trace_valid), DATA_W'(0));
        set_wb(3'd1, 2'd0, 8'h20, lanes(32'h2000));
        tick();
        check_eq("t3_wait_b", DATA_W'(bus.trace_valid), DATA_W'(0));
        set_wb(3'd1, 2'd1, 8'h21, lanes(32'h2100));
        tick();
        idle();
        check_eq("t3_wait_c", DATA_W'(bus.trace_valid), DATA_W'(0));
        tick();
        expect_beat("t3T", 32'h200, 3'd5, 3'b111, 8'h20, 8'h21, 8'h22,
                    lanes(32'h2000), lanes(32'h2100), lanes(32'h2200));

        // Full buffer, retire frees one entry, then pointer wrap
        do_reset();
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("t4_tag%0d", i), DATA_W'(bus.alloc_tag), DATA_W'(i));
            check_eq($sformatf("t4_rdy%0d", i), DATA_W'(bus.alloc_ready), DATA_W'(1));
            set_alloc(32'h1000 + 32'(i), 3'd0, 2'd1);
            tick();
        end
        idle();
        check_eq("t4_full", DATA_W'(bus.alloc_ready), DATA_W'(0));
        set_alloc(32'hDEAD, 3'd0, 2'd1);
        tick();
        idle();
        check_eq("t4_full_tag", DATA_W'(bus.alloc_tag), DATA_W'(0));
        check_eq("t4_full_hold", DATA_W'(bus.alloc_ready), DATA_W'(0));
        set_wb(3'd0, 2'd0, 8'd1, lanes(32'h1000));
        tick();
        idle();
        check_eq("t4_ret_cycle_rdy", DATA_W'(bus.alloc_ready), DATA_W'(0));
        tick();
        check_eq("t4_beat0", DATA_W'(bus.trace_valid), DATA_W'(1));
        check_eq("t4_beat0_pc", DATA_W'(bus.trace_pc), DATA_W'(32'h1000));
        check_eq("t4_rdy_after", DATA_W'(bus.alloc_ready), DATA_W'(1));
        check_eq("t4_wrap_tag", DATA_W'(bus.alloc_tag), DATA_W'(0));
        set_alloc(32'h1008, 3'd0, 2'd1);
        tick();
        idle();
        check_eq("t4_refull", DATA_W'(bus.alloc_ready), DATA_W'(0));
        check_eq("t4_tag_after_wrap", DATA_W'(bus.alloc_tag), DATA_W'(1));
        beat_pc_q.delete();
        for (int j = 1; j <= 8; j++) begin
            set_wb(3'(j % 8), 2'd0, 8'(j), lanes(32'(j)));
            tick();
        end
        idle();
        for (int j = 0; j < 4; j++) tick();
        check_eq("t4_drain_cnt", DATA_W'(beat_pc_q.size()), DATA_W'(8));
        for (int j = 0; j < 8; j++) begin
            if (j < beat_pc_q.size())
                check_eq($sformatf("t4_drain_pc%0d", j), DATA_W'(beat_pc_q[j]),
                         DATA_W'(32'h1001 + 32'(j)));
        end
        for (int i = 0; i < 20; i++) begin
            exp_tag = 3'((1 + i) % 8);
            check_eq($sformatf("t4_run_tag%0d", i), DATA_W'(bus.alloc_tag), DATA_W'(exp_tag));
            set_alloc(32'h3000 + 32'(i), 3'(i % 8), 2'd1);
            tick();
            idle();
            set_wb(exp_tag, 2'd0, 8'(i), lanes(32'(i * 16)));
            tick();
            idle();
            tick();
            check_eq($sformatf("t4_run_v%0d", i), DATA_W'(bus.trace_valid), DATA_W'(1));
            check_eq($sformatf("t4_run_pc%0d", i), DATA_W'(bus.trace_pc),
                     DATA_W'(32'h3000 + 32'(i)));
            check_eq($sformatf("t4_run_d%0d", i), bus.trace_regs_0_data, lanes(32'(i * 16)));
            tick();
        end

        // Protocol errors
        for (int k = 0; k < 4; k++) err_case(k);

        // Duplicate writeback leaves the first data in place
        do_reset();
        set_alloc(32'h500, 3'd6, 2'd2);
        tick();
        idle();
        set_wb(3'd0, 2'd0, 8'd9, lanes(32'h300));
        tick();
        check_eq("dup_err_before", DATA_W'(bus.err), DATA_W'(0));
        set_wb(3'd0, 2'd0, 8'd10, lanes(32'h400));
        tick();
        idle();
        check_eq("dup_err", DATA_W'(bus.err), DATA_W'(1));
        check_eq("dup_nobeat", DATA_W'(bus.trace_valid), DATA_W'(0));
        set_wb(3'd0, 2'd1, 8'd11, lanes(32'h500));
        tick();
        idle();
        tick();
        expect_beat("dup", 32'h500, 3'd6, 3'b011, 8'd9, 8'd11, 8'd0,
                    lanes(32'h300), lanes(32'h500), '0);
        check_eq("dup_err_sticky", DATA_W'(bus.err), DATA_W'(1));

        // Reset mid-operation discards pending entries and clears err
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_alloc(32'h600 + 32'(i), 3'd0, 2'd1);
            tick();
        end
        idle();
        set_wb(3'd5, 2'd0, 8'd0, '0);
        tick();
        set_wb(3'd1, 2'd0, 8'd1, lanes(32'h61));
        tick();
        set_wb(3'd2, 2'd0, 8'd2, lanes(32'h62));
        tick();
        idle();
        check_eq("mid_err_set", DATA_W'(bus.err), DATA_W'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        beat_pc_q.delete();
        tick();
        check_eq("mid_err_clr", DATA_W'(bus.err), DATA_W'(0));
        check_eq("mid_tag", DATA_W'(bus.alloc_tag), DATA_W'(0));
        check_eq("mid_ready", DATA_W'(bus.alloc_ready), DATA_W'(1));
        for (int i = 0; i < 5; i++) tick();
        check_eq("mid_nobeats", DATA_W'(beat_pc_q.size()), DATA_W'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
